// File: rtl/bus_pkg.sv
// Shared types, address map and decode helpers for the CPU-side bus responder.
package bus_pkg;

  localparam logic [15:0] HRAM_LO  = 16'hFF80;
  localparam logic [15:0] HRAM_HI  = 16'hFFFE;
  localparam logic [15:0] ADDR_IF  = 16'hFF0F;
  localparam logic [15:0] ADDR_IE  = 16'hFFFF;
  localparam logic [15:0] ADDR_DMA = 16'hFF46;
  localparam int          HRAM_DEPTH = int'(HRAM_HI - HRAM_LO) + 1;

  typedef enum logic [2:0] {
    REG_HRAM,
    REG_IF,
    REG_IE,
    REG_DMA,
    REG_EXT
  } region_t;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_READ,
    DMA_WRITE
  } dma_state_t;

  function automatic region_t decode_region(input logic [15:0] addr);
    region_t r;
    if (addr >= HRAM_LO && addr <= HRAM_HI) begin
      r = REG_HRAM;
    end else if (addr == ADDR_IF) begin
      r = REG_IF;
    end else if (addr == ADDR_IE) begin
      r = REG_IE;
    end else if (addr == ADDR_DMA) begin
      r = REG_DMA;
    end else begin
      r = REG_EXT;
    end
    return r;
  endfunction

  // Echo/WRAM mirror region (E0xx-FFxx) is folded back onto C0xx-DFxx.
  function automatic logic [7:0] dma_src_hi(input logic [7:0] src);
    return (src >= 8'hE0) ? (src - 8'h20) : src;
  endfunction

endpackage

// File: rtl/bus_responder_if.sv
// CPU-side bus and external memory port bundled between initiator and responder.
interface bus_responder_if;

  logic        cpu_rd_en;
  logic        cpu_wr_en;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        ext_rd;
  logic        ext_wr;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic [7:0]  ext_rdata;

  modport slave (
    input  cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wdata, ext_rdata,
    output cpu_rdata, ext_rd, ext_wr, ext_addr, ext_wdata
  );

  modport master (
    output cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wdata, ext_rdata,
    input  cpu_rdata, ext_rd, ext_wr, ext_addr, ext_wdata
  );

endinterface

// File: rtl/hram.sv
// High RAM: asynchronous read, synchronous write, contents survive reset.
module hram
  import bus_pkg::*;
(
  input  logic       clk,
  input  logic       we_i,
  input  logic [6:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [0:HRAM_DEPTH-1];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/bus_responder.sv
// Memory-side bus responder: HRAM, IF/IE, OAM DMA engine, and external forwarding.
module bus_responder
  import bus_pkg::*;
#(
  parameter int          DMA_LEN  = 160,
  parameter logic [15:0] OAM_BASE = 16'hFE00
)(
  input  logic          clk,
  input  logic          rst,
  bus_responder_if.slave bus,
  input  logic [4:0]    irq_req,
  input  logic          irq_ack,
  input  logic [2:0]    irq_ack_idx,
  output logic          irq_pending,
  output logic          dma_active
);

  localparam logic [7:0] DMA_LAST = 8'(DMA_LEN - 1);

  region_t    region_s;
  logic       hram_we_s;
  logic [7:0] hram_rdata_s;
  logic       if_wr_s;
  logic       ie_wr_s;
  logic       dma_wr_s;
  logic       dma_busy_s;

  logic [4:0] if_q;
  logic [4:0] if_d;
  logic [7:0] ie_q;
  logic [7:0] dma_src_q;
  logic [7:0] dma_idx_q;
  logic [7:0] dma_buf_q;
  dma_state_t dma_state_q;

  logic        ext_rd_s;
  logic        ext_wr_s;
  logic [15:0] ext_addr_s;
  logic [7:0]  ext_wdata_s;
  logic [7:0]  cpu_rdata_s;

  assign region_s   = decode_region(bus.cpu_addr);
  assign hram_we_s  = bus.cpu_wr_en && (region_s == REG_HRAM);
  assign if_wr_s    = bus.cpu_wr_en && (region_s == REG_IF);
  assign ie_wr_s    = bus.cpu_wr_en && (region_s == REG_IE);
  assign dma_wr_s   = bus.cpu_wr_en && (region_s == REG_DMA);
  assign dma_busy_s = (dma_state_q != DMA_IDLE);

  hram u_hram (
    .clk     (clk),
    .we_i    (hram_we_s),
    .addr_i  (bus.cpu_addr[6:0]),
    .wdata_i (bus.cpu_wdata),
    .rdata_o (hram_rdata_s)
  );

  // IF next state: request beats CPU write beats ack; out-of-range ack index matches no bit.
  always_comb begin
    if_d = if_q;
    for (int i = 0; i < 5; i++) begin
      if (irq_req[i]) begin
        if_d[i] = 1'b1;
      end else if (if_wr_s) begin
        if_d[i] = bus.cpu_wdata[i];
      end else if (irq_ack && (irq_ack_idx == 3'(i))) begin
        if_d[i] = 1'b0;
      end else begin
        if_d[i] = if_q[i];
      end
    end
  end

  // Interrupt flag and enable registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_q <= 5'h00;
      ie_q <= 8'h00;
    end else begin
      if_q <= if_d;
      if (ie_wr_s) begin
        ie_q <= bus.cpu_wdata;
      end
    end
  end

  // OAM DMA sequencer; a write to the DMA register restarts from index 0 in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      dma_state_q <= DMA_IDLE;
      dma_src_q   <= 8'h00;
      dma_idx_q   <= 8'h00;
      dma_buf_q   <= 8'h00;
    end else if (dma_wr_s) begin
      dma_src_q   <= bus.cpu_wdata;
      dma_idx_q   <= 8'h00;
      dma_state_q <= DMA_READ;
    end else begin
      case (dma_state_q)
        DMA_IDLE: begin
          dma_state_q <= DMA_IDLE;
        end
        DMA_READ: begin
          dma_buf_q   <= bus.ext_rdata;
          dma_state_q <= DMA_WRITE;
        end
        DMA_WRITE: begin
          dma_idx_q   <= dma_idx_q + 8'd1;
          dma_state_q <= (dma_idx_q == DMA_LAST) ? DMA_IDLE : DMA_READ;
        end
        default: begin
          dma_state_q <= DMA_IDLE;
        end
      endcase
    end
  end

  // External port: DMA owns it while active, otherwise CPU accesses to non-internal space pass through.
  always_comb begin
    ext_rd_s    = 1'b0;
    ext_wr_s    = 1'b0;
    ext_addr_s  = 16'h0000;
    ext_wdata_s = 8'h00;
    if (rst) begin
      ext_rd_s = 1'b0;
    end else if (dma_state_q == DMA_READ) begin
      ext_rd_s   = 1'b1;
      ext_addr_s = {dma_src_hi(dma_src_q), dma_idx_q};
    end else if (dma_state_q == DMA_WRITE) begin
      ext_wr_s    = 1'b1;
      ext_addr_s  = OAM_BASE + {8'h00, dma_idx_q};
      ext_wdata_s = dma_buf_q;
    end else begin
      ext_rd_s    = bus.cpu_rd_en && (region_s == REG_EXT);
      ext_wr_s    = bus.cpu_wr_en && (region_s == REG_EXT);
      ext_addr_s  = bus.cpu_addr;
      ext_wdata_s = bus.cpu_wdata;
    end
  end

  // CPU read mux; a concurrent write suppresses the read.
  always_comb begin
    cpu_rdata_s = 8'hFF;
    if (!bus.cpu_rd_en || bus.cpu_wr_en) begin
      cpu_rdata_s = 8'hFF;
    end else begin
      case (region_s)
        REG_HRAM: cpu_rdata_s = hram_rdata_s;
        REG_IF:   cpu_rdata_s = {3'b111, if_q};
        REG_IE:   cpu_rdata_s = ie_q;
        REG_DMA:  cpu_rdata_s = dma_src_q;
        REG_EXT:  cpu_rdata_s = dma_busy_s ? 8'hFF : bus.ext_rdata;
        default:  cpu_rdata_s = 8'hFF;
      endcase
    end
  end

  assign bus.ext_rd    = ext_rd_s;
  assign bus.ext_wr    = ext_wr_s;
  assign bus.ext_addr  = ext_addr_s;
  assign bus.ext_wdata = ext_wdata_s;
  assign bus.cpu_rdata = cpu_rdata_s;
  assign irq_pending   = |(ie_q[4:0] & if_q);
  assign dma_active    = !rst && dma_busy_s;

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder: directed scenarios plus randomized traffic against a behavioural model.
module tb_bus_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] irq_req;
  logic       irq_ack;
  logic [2:0] irq_ack_idx;
  logic       irq_pending;
  logic       dma_active;

  bus_responder_if bus_if ();

  bus_responder #(.DMA_LEN(160), .OAM_BASE(16'hFE00)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .irq_req     (irq_req),
    .irq_ack     (irq_ack),
    .irq_ack_idx (irq_ack_idx),
    .irq_pending (irq_pending),
    .dma_active  (dma_active)
  );

  always #5 clk = ~clk;

  // External memory contents: byte at page P offset O is O + C1 - P (so C100+i holds i).
  function automatic logic [7:0] ext_mem(input logic [15:0] a);
    return a[7:0] + 8'hC1 - a[15:8];
  endfunction

  always_comb bus_if.ext_rdata = bus_if.ext_rd ? ext_mem(bus_if.ext_addr) : 8'h00;

  typedef struct packed {
    logic       chk;
    logic       act;
    logic       pend;
    logic       rchk;
    logic [7:0] rdata;
  } cyc_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        wchk;
  } ext_t;

  cyc_t cyc_q[$];
  ext_t ext_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state.
  logic [7:0] m_hram [0:126];
  bit         m_hv   [0:126];
  logic [4:0] m_if;
  logic [7:0] m_ie;
  logic [7:0] m_src;
  int         m_step;  // cycles elapsed in the current transfer, -1 when none

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_hram(input logic [15:0] a);
    return (a >= 16'hFF80) && (a <= 16'hFFFE);
  endfunction

  function automatic bit is_internal(input logic [15:0] a);
    return is_hram(a) || a == 16'hFF0F || a == 16'hFFFF || a == 16'hFF46;
  endfunction

  // One bus cycle: queue expectations, cross the clock edge, advance the model.
  task automatic step(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] wd,
                      input logic [4:0] req, input logic ack, input logic [2:0] aidx, input logic r);
    cyc_t       c;
    ext_t       e;
    int         idx;
    logic [7:0] shi;
    logic [4:0] ack_mask;
    rst = r; bus_if.cpu_rd_en = rd; bus_if.cpu_wr_en = wr; bus_if.cpu_addr = a; bus_if.cpu_wdata = wd;
    irq_req = req; irq_ack = ack; irq_ack_idx = aidx;

    c.chk  = 1'b1;
    c.act  = !r && (m_step >= 0);
    c.pend = |(m_ie[4:0] & m_if);
    c.rchk = !r;
    if (!rd || wr)               c.rdata = 8'hFF;
    else if (is_hram(a)) begin   c.rdata = m_hram[int'(a - 16'hFF80)]; c.rchk = c.rchk && m_hv[int'(a - 16'hFF80)]; end
    else if (a == 16'hFF0F)      c.rdata = {3'b111, m_if};
    else if (a == 16'hFFFF)      c.rdata = m_ie;
    else if (a == 16'hFF46)      c.rdata = m_src;
    else if (m_step >= 0)        c.rdata = 8'hFF;
    else                         c.rdata = ext_mem(a);
    cyc_q.push_back(c);

    if (!r && m_step >= 0) begin
      idx = m_step / 2;
      shi = (m_src >= 8'hE0) ? m_src - 8'h20 : m_src;
      if (m_step % 2 == 0) begin
        e.rd = 1'b1; e.wr = 1'b0; e.addr = {shi, 8'(idx)}; e.wdata = 8'h00; e.wchk = 1'b0;
      end else begin
        e.rd = 1'b0; e.wr = 1'b1; e.addr = 16'hFE00 + 16'(idx); e.wdata = ext_mem({shi, 8'(idx)}); e.wchk = 1'b1;
      end
      ext_q.push_back(e);
    end else if (!r && !is_internal(a) && (rd || wr)) begin
      e.rd = rd; e.wr = wr; e.addr = a; e.wdata = wd; e.wchk = wr;
      ext_q.push_back(e);
    end

    @(posedge clk);
    if (r) begin
      m_if = 5'h00; m_ie = 8'h00; m_src = 8'h00; m_step = -1;
    end else begin
      if (wr && is_hram(a)) begin
        m_hram[int'(a - 16'hFF80)] = wd;
        m_hv[int'(a - 16'hFF80)]   = 1'b1;
      end
      ack_mask = (ack && aidx < 3'd5) ? (5'b00001 << aidx) : 5'b00000;
      m_if = ((wr && a == 16'hFF0F) ? wd[4:0] : (m_if & ~ack_mask)) | req;
      if (wr && a == 16'hFFFF) m_ie = wd;
      if (m_step >= 0) m_step = (m_step == 319) ? -1 : m_step + 1;
      if (wr && a == 16'hFF46) begin m_src = wd; m_step = 0; end
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0000, 8'h00, 5'h00, 1'b0, 3'd0, 1'b0);
  endtask
  task automatic rd(input logic [15:0] a);
    step(1'b1, 1'b0, a, 8'h00, 5'h00, 1'b0, 3'd0, 1'b0);
  endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    step(1'b0, 1'b1, a, d, 5'h00, 1'b0, 3'd0, 1'b0);
  endtask

  // Monitor: per-cycle status/read data, plus every external strobe the DUT presents.
  initial begin
    cyc_t c;
    ext_t e;
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        if (c.chk) begin
          check("dma_active", 32'(dma_active), 32'(c.act));
          check("irq_pending", 32'(irq_pending), 32'(c.pend));
          if (c.rchk) check("cpu_rdata", 32'(bus_if.cpu_rdata), 32'(c.rdata));
        end
      end
      if (bus_if.ext_rd || bus_if.ext_wr) begin
        if (ext_q.size() == 0) begin
          check("ext_unexpected_strobe", {14'h0, bus_if.ext_rd, bus_if.ext_wr, bus_if.ext_addr}, 32'h0);
        end else begin
          e = ext_q.pop_front();
          check("ext_strobes", {30'h0, bus_if.ext_rd, bus_if.ext_wr}, {30'h0, e.rd, e.wr});
          check("ext_addr", 32'(bus_if.ext_addr), 32'(e.addr));
          if (e.wchk) check("ext_wdata", 32'(bus_if.ext_wdata), 32'(e.wdata));
        end
      end
    end
  end

  initial begin
    int k;
    logic [15:0] a;
    logic [4:0]  req;
    logic        ack;
    logic        both;
    for (int i = 0; i < 127; i++) m_hv[i] = 1'b0;
    rst = 1'b1; bus_if.cpu_rd_en = 1'b0; bus_if.cpu_wr_en = 1'b0; bus_if.cpu_addr = 16'h0000;
    bus_if.cpu_wdata = 8'h00; irq_req = 5'h00; irq_ack = 1'b0; irq_ack_idx = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    m_if = 5'h00; m_ie = 8'h00; m_src = 8'h00; m_step = -1;

    // Reset state.
    idle(); rd(16'hFF0F); rd(16'hFFFF); rd(16'hFF46);
    // HRAM boundaries.
    wr(16'hFF80, 8'h5A); wr(16'hFFFE, 8'hC3); rd(16'hFF80); rd(16'hFFFE);
    // External forwarding and idle bus.
    rd(16'hC123); idle(); wr(16'hC456, 8'h9E); rd(16'hFF7F);
    // Interrupt priority.
    wr(16'hFFFF, 8'h05);
    step(1'b0, 1'b1, 16'hFF0F, 8'h00, 5'b00100, 1'b0, 3'd0, 1'b0);
    rd(16'hFF0F);
    step(1'b0, 1'b0, 16'h0000, 8'h00, 5'h00, 1'b1, 3'd6, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 8'h00, 5'h00, 1'b1, 3'd2, 1'b0);
    rd(16'hFF0F);
    // Simultaneous read and write: write wins.
    step(1'b1, 1'b1, 16'hFF80, 8'h11, 5'h00, 1'b0, 3'd0, 1'b0);
    rd(16'hFF80);
    // Full DMA with CPU traffic during the transfer.
    wr(16'hFF46, 8'hC1);
    for (int i = 0; i < 330; i++) begin
      if (i == 40) rd(16'hFF80);
      else if (i == 41) rd(16'h8000);
      else if (i == 42) wr(16'h8000, 8'h55);
      else if (i == 43) wr(16'hFF81, 8'h66);
      else if (i == 44) rd(16'hFF81);
      else if (i == 45) rd(16'hFF46);
      else idle();
    end
    // Mirrored source page.
    wr(16'hFF46, 8'hF0);
    repeat (325) idle();
    // Restart mid-transfer.
    wr(16'hFF46, 8'hC1);
    repeat (101) idle();
    wr(16'hFF46, 8'hC2);
    repeat (325) idle();
    // Reset during a write phase.
    wr(16'hFF46, 8'hC1);
    repeat (5) idle();
    step(1'b0, 1'b0, 16'h0000, 8'h00, 5'h00, 1'b0, 3'd0, 1'b1);
    repeat (4) idle();
    rd(16'hFF46); rd(16'hFF80);
    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      k    = int'($urandom_range(0, 999));
      req  = ($urandom_range(0, 7) == 0) ? (5'b00001 << $urandom_range(0, 4)) : 5'h00;
      ack  = ($urandom_range(0, 3) == 0);
      both = ($urandom_range(0, 19) == 0);
      if (k < 3)        a = 16'hFF46;
      else if (k < 10)  a = 16'hFF46;
      else if (k < 300) a = 16'hFF80 + 16'($urandom_range(0, 126));
      else if (k < 400) a = 16'hFF0F;
      else if (k < 450) a = 16'hFFFF;
      else              a = 16'($urandom_range(0, 16'hFF7F));
      if (k < 3) begin
        step(1'b0, 1'b1, a, 8'($urandom_range(0, 255)), req, ack, 3'($urandom_range(0, 7)), 1'b0);
      end else if (k >= 10 && $urandom_range(0, 2) == 0) begin
        step(both, 1'b1, a, 8'($urandom_range(0, 255)), req, ack, 3'($urandom_range(0, 7)), 1'b0);
      end else begin
        step($urandom_range(0, 4) != 0, 1'b0, a, 8'h00, req, ack, 3'($urandom_range(0, 7)), 1'b0);
      end
    end
    repeat (330) idle();
    @(negedge clk);
    #1;
    check("ext_queue_drained", 32'(ext_q.size()), 32'd0);
    check("cycle_queue_drained", 32'(cyc_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Memory-side counterpart of the CPU bus initiator. Answers CPU rd_en/wr_en cycles.
- Internally serves HRAM (FF80–FFFE), IF (FF0F), IE (FFFF) and the OAM DMA register (FF46).
- Forwards every other address to an external memory port.
- Owns the OAM DMA engine, which masters the external port while a transfer is active.

Parameters:
- DMA_LEN, 160, bytes per OAM DMA transfer.
- OAM_BASE, 16'hFE00, DMA destination base address.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cpu_rd_en  in  1  CPU read strobe
- cpu_wr_en  in  1  CPU write strobe
- cpu_addr  in  16  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  read data, combinational from cpu_addr, same cycle
- irq_req  in  5  interrupt request pulses (VBlank, STAT, Timer, Serial, Joypad)
- irq_ack  in  1  clear one IF bit
- irq_ack_idx  in  3  IF bit to clear (0–4)
- irq_pending  out  1  |(IE[4:0] & IF[4:0]), combinational
- dma_active  out  1  DMA in progress
- ext_rd  out  1  external read strobe
- ext_wr  out  1  external write strobe
- ext_addr  out  16  external address
- ext_wdata  out  8  external write data
- ext_rdata  in  8  external read data, combinational, same cycle

Behaviour:
- Reset values:
  - IF=5'h00, IE=8'h00, dma_src=8'h00, dma state IDLE, dma_idx=0.
  - dma_active=0, ext_rd=0, ext_wr=0, ext_addr=0, ext_wdata=0.
  - HRAM contents are not reset.
- Read path (0 wait states): the CPU latches cpu_rdata at the posedge where cpu_rd_en=1.
  - FF80–FFFE: HRAM[addr-FF80].
  - FF0F: {3'b111, IF}.
  - FFFF: IE.
  - FF46: dma_src.
  - Otherwise: ext_rdata.
  - cpu_rd_en=0: 8'hFF.
- Write path: takes effect at the posedge with cpu_wr_en=1. If cpu_rd_en and cpu_wr_en are both high, the write wins and cpu_rdata=8'hFF.
- External forwarding when DMA is idle:
  - ext_rd=cpu_rd_en and ext_wr=cpu_wr_en, only for non-internal addresses.
  - ext_addr=cpu_addr; ext_wdata=cpu_wdata.
  - Internal addresses: ext strobes stay 0.
- IF update priority per bit, highest first:
  1. irq_req set
  2. CPU write to FF0F (wdata[4:0])
  3. irq_ack clear
  4. hold
- IF rules: a request pulse coincident with a write or ack leaves the bit set. irq_ack_idx>4 is ignored. IF[7:5] always read 1.
- DMA FSM states: IDLE, READ, WRITE.
  - CPU write to FF46 (any state): dma_src<=wdata, dma_idx<=0, next state READ. A write mid-transfer restarts the transfer.
  - Source high byte: src_hi = dma_src≥8'hE0 ? dma_src-8'h20 : dma_src.
  - READ: ext_rd=1, ext_addr={src_hi, dma_idx}, latch ext_rdata into dma_buf, go to WRITE.
  - WRITE: ext_wr=1, ext_addr=OAM_BASE+dma_idx, ext_wdata=dma_buf, dma_idx++. Go to IDLE if dma_idx==DMA_LEN-1, else to READ.
  - Transfer length: 2·DMA_LEN = 320 cycles after the trigger cycle. dma_active=1 in READ and WRITE.
- CPU access during DMA:
  - HRAM, IF, IE and FF46 are fully accessible.
  - Other reads return 8'hFF; other writes are dropped.
  - The ext port is driven only by DMA.
- Reset mid-DMA aborts the transfer immediately; no further ext strobes.

Decomposition:
- bus_pkg holds:
  - region_t enum (REG_HRAM, REG_IF, REG_IE, REG_DMA, REG_EXT).
  - dma_state_t enum (DMA_IDLE, DMA_READ, DMA_WRITE).
  - Address constants: HRAM_LO/HI, ADDR_IF, ADDR_IE, ADDR_DMA.
- One sub-module, hram: 127×8, asynchronous read, synchronous write, no reset.
- Address decode is a pure function in bus_pkg.

Test Plan:
- Write HRAM FF80←5A, FFFE←C3, then read both → 5A, C3. ext_rd/ext_wr stay 0 throughout.
- Read C123 with ext_rdata=77 → cpu_rdata=77, ext_rd=1, ext_addr=C123. Idle bus → cpu_rdata=FF.
- IE←05. irq_req=00100 at the same posedge as CPU write FF0F←00 → FF0F reads E4, irq_pending=1. irq_ack idx 2 → FF0F reads E0, irq_pending=0.
- FF46←C1 with ext memory C100+i=i → 320 cycles of alternating strobes. Write at FE00+i with data i for i=0..159. dma_active falls after the last write. Mid-transfer: CPU read FF80 works; CPU read 8000 → FF.
- FF46←F0 → DMA reads start at D000.
- Restart FF46←C2 at idx 50 → idx resets to 0, source C200. Separately, assert rst during WRITE → all ext strobes 0 next cycle, dma_active=0.
